// File: rtl/branch_resolve_if.sv
// Bundle between the ID/EX pipeline controls and the branch resolution block.
//   Inputs to branch_resolve (driven by the master side):
//     id_valid, id_BS, id_PS, id_BrA, id_RAA  decoded branch in ID
//     stall                                   pipeline freeze
//     ex_zero                                 ALU zero flag for the EX instruction
//   Outputs from branch_resolve (driven by the slave side):
//     redirect, redirect_pc                   one-cycle fetch redirect
//     flush_if, flush_id                      wrong-path squash
//     busy                                    EX occupied or flushing
//     br_count, taken_count                   branch statistics (CW bits)
//     dbg_state                               FSM state (IDLE=0, EXEC=1, FLUSH=2)
// Handshake: there is no backpressure. A branch offered with id_valid=1 is
// taken into EX only in a cycle with stall=0 while EX is free or resolving
// not-taken; in any other cycle the offer is simply not captured.
interface branch_resolve_if #(
    parameter int CW = 16
);
    logic          id_valid;
    logic [1:0]    id_BS;
    logic          id_PS;
    logic [31:0]   id_BrA;
    logic [31:0]   id_RAA;
    logic          stall;
    logic          ex_zero;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          flush_if;
    logic          flush_id;
    logic          busy;
    logic [CW-1:0] br_count;
    logic [CW-1:0] taken_count;
    logic [1:0]    dbg_state;

    modport master (
        output id_valid, id_BS, id_PS, id_BrA, id_RAA, stall, ex_zero,
        input  redirect, redirect_pc, flush_if, flush_id, busy,
               br_count, taken_count, dbg_state
    );

    modport slave (
        input  id_valid, id_BS, id_PS, id_BrA, id_RAA, stall, ex_zero,
        output redirect, redirect_pc, flush_if, flush_id, busy,
               br_count, taken_count, dbg_state
    );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution and pipeline-redirect controller.
// Latches the decoded branch from ID into an EX register, resolves it against
// the ALU zero flag, issues a registered one-cycle redirect on a taken branch,
// then squashes IF/ID for FLUSH_CYCLES cycles. Keeps branch statistics.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    branch_resolve_if.slave (see interface header for signal list)
// Parameters:
//   FLUSH_CYCLES  flush length after a taken branch (1..15)
//   CW            statistics counter width (must match the interface CW)
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CW           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_resolve_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    ex_bs;
    logic          ex_ps;
    logic [31:0]   ex_bra;
    logic [31:0]   ex_raa;
    logic [3:0]    flush_cnt;
    logic          redirect_r;
    logic [31:0]   redirect_pc_r;
    logic          flush_r;
    logic [CW-1:0] br_r;
    logic [CW-1:0] taken_r;

    logic          ex_valid;
    logic          taken;
    logic [31:0]   target;

    // EX holds a live branch exactly while in EXEC.
    assign ex_valid = (state == EXEC);
    // Same select equation the PC mux uses.
    assign taken    = ex_bs[1] | (ex_bs[0] & (ex_ps ^ bus.ex_zero));
    assign target   = (ex_bs == 2'b10) ? ex_raa : ex_bra;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ex_bs         <= 2'b00;
            ex_ps         <= 1'b0;
            ex_bra        <= 32'd0;
            ex_raa        <= 32'd0;
            flush_cnt     <= 4'd0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
            flush_r       <= 1'b0;
            br_r          <= '0;
            taken_r       <= '0;
        end else begin
            redirect_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.id_valid && !bus.stall) begin
                        ex_bs  <= bus.id_BS;
                        ex_ps  <= bus.id_PS;
                        ex_bra <= bus.id_BrA;
                        ex_raa <= bus.id_RAA;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // A stall freezes EX completely: no resolve, no count.
                    if (!bus.stall) begin
                        if (ex_bs != 2'b00) begin
                            br_r <= br_r + CW'(1);
                        end
                        if (taken) begin
                            // The ID instruction is on the wrong path; it is dropped.
                            taken_r       <= taken_r + CW'(1);
                            redirect_r    <= 1'b1;
                            redirect_pc_r <= target;
                            flush_r       <= 1'b1;
                            flush_cnt     <= 4'(FLUSH_CYCLES);
                            state         <= FLUSH;
                        end else if (bus.id_valid) begin
                            ex_bs  <= bus.id_BS;
                            ex_ps  <= bus.id_PS;
                            ex_bra <= bus.id_BrA;
                            ex_raa <= bus.id_RAA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    // Counts down regardless of stall; id_valid is ignored here.
                    if (flush_cnt <= 4'd1) begin
                        flush_cnt <= 4'd0;
                        flush_r   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.redirect    = redirect_r;
    assign bus.redirect_pc = redirect_pc_r;
    assign bus.flush_if    = flush_r;
    assign bus.flush_id    = flush_r;
    assign bus.busy        = (state != IDLE);
    assign bus.br_count    = br_r;
    assign bus.taken_count = taken_r;
    assign bus.dbg_state   = state;

endmodule
